// File: rtl/sum_window_acc_pkg.sv
// Shared types and sizing helpers for the window accumulator and its downstream serialiser.
// No logic of its own.
// No flow control of its own.
package sum_window_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 8;
  localparam int WINDOW_DEF = 4;

  // Accumulator width that holds WINDOW full-scale samples without wrap.
  function automatic int acc_w(input int data_w, input int window);
    return data_w + $clog2(window);
  endfunction

endpackage

// File: rtl/sum_window_acc_if.sv
// Sample-in / window-out port bundle of sum_window_acc. Wires only, so no latency.
// Both directions use valid/ready. flush travels with the input side.
interface sum_window_acc_if
  import sum_window_acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WINDOW = WINDOW_DEF
);
  localparam int ACC_W = acc_w(DATA_W, WINDOW);
  localparam int CNT_W = $clog2(WINDOW) + 1;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_count, out_valid
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_count, out_valid
  );

endinterface

// File: rtl/sum_window_acc.sv
// Sums WINDOW samples, or fewer if flushed, and emits the total and count. Define SUM_WINDOW_ACC_AVERAGE_EN to emit the rounded mean on full windows.
// Latency: out_valid rises the cycle after the closing sample or flush.
// Backpressure: in_ready drops while a result waits in HOLD, giving at least one bubble per window.
module sum_window_acc
  import sum_window_acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  sum_window_acc_if.slave  bus
);

  localparam int ACC_W = acc_w(DATA_W, WINDOW);
  localparam int CNT_W = $clog2(WINDOW) + 1;
  localparam logic [CNT_W-1:0] WINDOW_CNT = CNT_W'(WINDOW);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic [ACC_W-1:0] sum_in;
  logic [ACC_W-1:0] full_val;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  assign accept  = bus.in_valid && (state_q == ACCUM);
  assign sum_in  = acc_q + ACC_W'(bus.in_data);
  assign cnt_inc = cnt_q + 1'b1;

`ifdef SUM_WINDOW_ACC_AVERAGE_EN
  // Round-half-up mean. The added WINDOW/2 cannot overflow ACC_W.
  assign full_val = (sum_in + ACC_W'(WINDOW / 2)) >> $clog2(WINDOW);
`else
  assign full_val = sum_in;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = sum_in;
          cnt_d = cnt_inc;
          if (cnt_inc == WINDOW_CNT) begin
            out_data_d  = full_val;
            out_count_d = cnt_inc;
            state_d     = HOLD;
          end else if (bus.flush) begin
            out_data_d  = sum_in;
            out_count_d = cnt_inc;
            state_d     = HOLD;
          end
        end else if (bus.flush && (cnt_q != '0)) begin
          // A flush on an empty window is dropped, so no zero-count result is ever emitted.
          out_data_d  = acc_q;
          out_count_d = cnt_q;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_sum_window_acc.sv
// Directed bench for sum_window_acc with WINDOW=4 and DATA_W=8. Expected values are hand-computed.
// It also builds with SUM_WINDOW_ACC_AVERAGE_EN defined, in which case full windows expect the rounded mean.
module tb_sum_window_acc;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  sum_window_acc_if #(.DATA_W(8), .WINDOW(4)) bus ();

  sum_window_acc #(.DATA_W(8), .WINDOW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int full_exp(input int s);
`ifdef SUM_WINDOW_ACC_AVERAGE_EN
    return (s + 2) / 4;
`else
    return s;
`endif
  endfunction

  // Inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int d);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(d);
    tick();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int data, input int count);
    check({tag, ".valid"}, int'(bus.out_valid), 1);
    check({tag, ".data"},  int'(bus.out_data),  data);
    check({tag, ".count"}, int'(bus.out_count), count);
    check({tag, ".in_rdy"}, int'(bus.in_ready), 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle();
    check("rst.valid", int'(bus.out_valid), 0);
    check("rst.in_rdy", int'(bus.in_ready), 1);
    check("rst.data", int'(bus.out_data), 0);
    check("rst.count", int'(bus.out_count), 0);
    // Samples offered during reset must not have been counted, so a flush here is ignored.
    bus.flush = 1'b1;
    tick();
    idle();
    check("rst_discard.valid", int'(bus.out_valid), 0);

    // Back-to-back full window.
    feed(10);
    feed(20);
    feed(30);
    check("b2b.mid_valid", int'(bus.out_valid), 0);
    check("b2b.mid_rdy", int'(bus.in_ready), 1);
    feed(40);
    idle();
    expect_out("b2b", full_exp(100), 4);
    tick();
    check("b2b.drop_valid", int'(bus.out_valid), 0);
    check("b2b.rdy_back", int'(bus.in_ready), 1);
    check("b2b.data_kept", int'(bus.out_data), full_exp(100));

    // Full-scale window must not wrap.
    for (int i = 0; i < 4; i++) feed(255);
    idle();
    expect_out("max", full_exp(1020), 4);
    tick();

    // Flush on its own closes a partial window, which is raw even with averaging.
    feed(255);
    feed(255);
    idle();
    bus.flush = 1'b1;
    tick();
    idle();
    expect_out("flush2", 510, 2);
    tick();
    bus.flush = 1'b1;
    tick();
    idle();
    check("flush0.valid", int'(bus.out_valid), 0);
    check("flush0.in_rdy", int'(bus.in_ready), 1);

    // Flush in the same cycle as the third sample.
    feed(1);
    feed(2);
    bus.flush = 1'b1;
    feed(5);
    idle();
    expect_out("flush3", 8, 3);
    tick();

    // Stall the output for 5 cycles. Inputs and flush must be ignored.
    bus.out_ready = 1'b0;
    feed(1);
    feed(2);
    feed(3);
    feed(4);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd77;
    bus.flush    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out($sformatf("stall%0d", i), full_exp(10), 4);
    end
    idle();
    bus.out_ready = 1'b1;
    tick();
    check("stall.release", int'(bus.out_valid), 0);
    bus.flush = 1'b1;
    feed(9);
    idle();
    expect_out("fresh", 9, 1);
    tick();

    // Reset in the middle of a window discards the partial sum.
    feed(3);
    feed(3);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid.valid", int'(bus.out_valid), 0);
    check("rst_mid.in_rdy", int'(bus.in_ready), 1);
    for (int i = 0; i < 4; i++) feed(1);
    idle();
    expect_out("after_rst", full_exp(4), 4);
    tick();

    // Reset while holding a result clears every output.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed(2);
    idle();
    check("hold_pre.valid", int'(bus.out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_hold.valid", int'(bus.out_valid), 0);
    check("rst_hold.data", int'(bus.out_data), 0);
    check("rst_hold.count", int'(bus.out_count), 0);
    check("rst_hold.in_rdy", int'(bus.in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
